// File: rtl/lif_cfg_pkg.sv
// rtl/lif_cfg_pkg.sv - shared types and defaults for the LIF parameter loader
// Contents: loader FSM state type, default field width, per-channel reset values.
package lif_cfg_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } lif_state_e;

    localparam int         DATA_W_DEF     = 8;
    localparam logic [7:0] RST_TAU_DEF    = 8'd4;
    localparam logic [7:0] RST_WEIGHT_DEF = 8'd1;
    localparam logic [7:0] RST_THRESH_DEF = 8'd64;

endpackage

// File: rtl/lif_param_shift.sv
// rtl/lif_param_shift.sv - one serial shadow register with LSB-first bit insert
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start_i      first bit of a frame: clear shadow, write din_i to bit 0
//   load_i       later bits of a frame: write din_i to bit idx_i
//   idx_i        bit position for load_i
//   din_i        serial data bit
//   shadow_o     assembled shadow value
module lif_param_shift
    import lif_cfg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              load_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              din_i,
    output logic [DATA_W-1:0] shadow_o
);

    logic [DATA_W-1:0] shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (start_i) begin
            // Clearing on the first bit keeps stale bits of a previous frame out.
            shadow_q    <= '0;
            shadow_q[0] <= din_i;
        end else if (load_i) begin
            shadow_q[idx_i] <= din_i;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/lif_param_loader.sv
// rtl/lif_param_loader.sv - serial tau/weight/threshold loader for N_CH LIF channels
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   set_vars                 frame enable, high for DATA_W cycles per frame
//   ch_sel                   target channel, sampled on the first frame cycle
//   expd, w, t               serial tau / weight / threshold bits, LSB first
//   tau, weight, threshold   per-channel registers, channel k at [k*DATA_W +: DATA_W]
//   busy                     frame being shifted
//   cfg_done, frame_err      one-cycle commit / reject pulses
//   ch_loaded                sticky per-channel configured flags
module lif_param_loader
    import lif_cfg_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                N_CH       = 4,
    parameter logic [DATA_W-1:0] RST_TAU    = RST_TAU_DEF,
    parameter logic [DATA_W-1:0] RST_WEIGHT = RST_WEIGHT_DEF,
    parameter logic [DATA_W-1:0] RST_THRESH = RST_THRESH_DEF,
    localparam int               CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_vars,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic                     expd,
    input  logic                     w,
    input  logic                     t,
    output logic [N_CH*DATA_W-1:0]   tau,
    output logic [N_CH*DATA_W-1:0]   weight,
    output logic [N_CH*DATA_W-1:0]   threshold,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     frame_err,
    output logic [N_CH-1:0]          ch_loaded
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    lif_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              start, load, commit, reject, ch_valid;
    logic              cfg_done_q, frame_err_q;
    logic [N_CH-1:0]   ch_loaded_q;
    logic [N_CH*DATA_W-1:0] tau_q, weight_q, thresh_q;
    logic [DATA_W-1:0] sh_tau, sh_weight, sh_thresh;

    // Extra MSB keeps the range check meaningful when N_CH is a power of two.
    assign ch_valid = ({1'b0, ch_q} < (CH_W+1)'(N_CH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ch_d    = ch_q;
        start   = 1'b0;
        load    = 1'b0;
        commit  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_vars) begin
                    start   = 1'b1;
                    ch_d    = ch_sel;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            default: begin
                if (set_vars) begin
                    if (cnt_q < CNT_W'(DATA_W)) begin
                        load  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        // Counter saturates; the frame is remembered as too long.
                        ovf_d = 1'b1;
                    end
                end else begin
                    if (cnt_q == CNT_W'(DATA_W) && !ovf_q && ch_valid) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
        endcase
    end

    lif_param_shift #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_shift_tau (
        .clk(clk), .rst(rst), .start_i(start), .load_i(load),
        .idx_i(cnt_q[IDX_W-1:0]), .din_i(expd), .shadow_o(sh_tau)
    );
    lif_param_shift #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_shift_weight (
        .clk(clk), .rst(rst), .start_i(start), .load_i(load),
        .idx_i(cnt_q[IDX_W-1:0]), .din_i(w), .shadow_o(sh_weight)
    );
    lif_param_shift #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_shift_thresh (
        .clk(clk), .rst(rst), .start_i(start), .load_i(load),
        .idx_i(cnt_q[IDX_W-1:0]), .din_i(t), .shadow_o(sh_thresh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ch_q        <= '0;
            cfg_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ch_loaded_q <= '0;
            tau_q       <= {N_CH{RST_TAU}};
            weight_q    <= {N_CH{RST_WEIGHT}};
            thresh_q    <= {N_CH{RST_THRESH}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            ch_q        <= ch_d;
            cfg_done_q  <= commit;
            frame_err_q <= reject;
            // All three fields of the selected channel update on the same edge.
            for (int k = 0; k < N_CH; k++) begin
                if (commit && ch_q == CH_W'(k)) begin
                    tau_q[k*DATA_W +: DATA_W]    <= sh_tau;
                    weight_q[k*DATA_W +: DATA_W] <= sh_weight;
                    thresh_q[k*DATA_W +: DATA_W] <= sh_thresh;
                    ch_loaded_q[k]               <= 1'b1;
                end
            end
        end
    end

    assign tau       = tau_q;
    assign weight    = weight_q;
    assign threshold = thresh_q;
    assign busy      = (state_q == SHIFT);
    assign cfg_done  = cfg_done_q;
    assign frame_err = frame_err_q;
    assign ch_loaded = ch_loaded_q;

endmodule

// File: tb/tb_lif_param_loader.sv
// tb/tb_lif_param_loader.sv - self-checking bench for lif_param_loader
module tb_lif_param_loader;

    logic        clk = 1'b0;
    logic        rst, set_vars, expd, w, t;
    logic [1:0]  ch_sel;
    logic [2:0]  ch_sel2;
    logic [31:0] tau1, wt1, th1;
    logic [39:0] tau2, wt2, th2;
    logic        busy1, done1, err1, busy2, done2, err2;
    logic [3:0]  ld1;
    logic [4:0]  ld2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lif_param_loader #(.N_CH(4)) dut (
        .clk(clk), .rst(rst), .set_vars(set_vars), .ch_sel(ch_sel),
        .expd(expd), .w(w), .t(t), .tau(tau1), .weight(wt1), .threshold(th1),
        .busy(busy1), .cfg_done(done1), .frame_err(err1), .ch_loaded(ld1)
    );

    // Five channels so that ch_sel values >= N_CH are representable.
    lif_param_loader #(.N_CH(5)) dut2 (
        .clk(clk), .rst(rst), .set_vars(set_vars), .ch_sel(ch_sel2),
        .expd(expd), .w(w), .t(t), .tau(tau2), .weight(wt2), .threshold(th2),
        .busy(busy2), .cfg_done(done2), .frame_err(err2), .ch_loaded(ld2)
    );

    // Reference model: per-channel field values, loaded flags, expected pulses.
    logic [7:0] m1_tau [4], m1_wt [4], m1_th [4];
    logic [7:0] m2_tau [5], m2_wt [5], m2_th [5];
    logic [3:0] m1_ld;
    logic [4:0] m2_ld;
    logic       e_done1, e_err1, e_done2, e_err2;
    logic       o_done1, o_err1, o_done2, o_err2, o_busy, o_early;

    function automatic logic [31:0] flat1(input int f);
        logic [31:0] v;
        for (int k = 0; k < 4; k++)
            v[k*8 +: 8] = (f == 0) ? m1_tau[k] : (f == 1) ? m1_wt[k] : m1_th[k];
        return v;
    endfunction

    function automatic logic [39:0] flat2(input int f);
        logic [39:0] v;
        for (int k = 0; k < 5; k++)
            v[k*8 +: 8] = (f == 0) ? m2_tau[k] : (f == 1) ? m2_wt[k] : m2_th[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin m1_tau[k] = 8'd4; m1_wt[k] = 8'd1; m1_th[k] = 8'd64; end
            m2_tau[k] = 8'd4; m2_wt[k] = 8'd1; m2_th[k] = 8'd64;
        end
        m1_ld = '0;
        m2_ld = '0;
    endtask

    // A frame is accepted only if exactly 8 bits arrived and the channel exists.
    task automatic model_frame(input int len, input int c1, input int c2,
                               input logic [7:0] tv, input logic [7:0] wv, input logic [7:0] thv);
        e_done1 = (len == 8) && (c1 < 4);
        e_err1  = !e_done1;
        e_done2 = (len == 8) && (c2 < 5);
        e_err2  = !e_done2;
        if (e_done1) begin m1_tau[c1] = tv; m1_wt[c1] = wv; m1_th[c1] = thv; m1_ld[c1] = 1'b1; end
        if (e_done2) begin m2_tau[c2] = tv; m2_wt[c2] = wv; m2_th[c2] = thv; m2_ld[c2] = 1'b1; end
    endtask

    task automatic send_frame(input int len, input int c1, input int c2,
                              input logic [7:0] tv, input logic [7:0] wv, input logic [7:0] thv,
                              input bit tog);
        logic [1:0] s1;
        logic [2:0] s2;
        s1 = c1[1:0];
        s2 = c2[2:0];
        for (int i = 0; i < len; i++) begin
            set_vars = 1'b1;
            expd    = (i < 8) ? tv[i]  : 1'($urandom);
            w       = (i < 8) ? wv[i]  : 1'($urandom);
            t       = (i < 8) ? thv[i] : 1'($urandom);
            ch_sel  = (i == 0 || !tog) ? s1 : ~s1;
            ch_sel2 = (i == 0 || !tog) ? s2 : ~s2;
            @(posedge clk); #1;
            if (i == 0) begin
                o_busy  = busy1;
                o_early = done1 | err1 | done2 | err2;
            end
        end
        set_vars = 1'b0;
        ch_sel   = 2'($urandom);
        ch_sel2  = 3'($urandom);
        @(posedge clk); #1;
        o_done1 = done1; o_err1 = err1; o_done2 = done2; o_err2 = err2;
        model_frame(len, c1, c2, tv, wv, thv);
    endtask

    task automatic test_reset();
        rst = 1'b1; set_vars = 1'b0; ch_sel = '0; ch_sel2 = '0; expd = 0; w = 0; t = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_checks++;
        if (tau1 !== 32'h04040404 || wt1 !== 32'h01010101 || th1 !== 32'h40404040) begin
            n_fail++;
            $display("FAIL reset_values tau=%h w=%h th=%h want 04040404/01010101/40404040", tau1, wt1, th1);
        end
        n_checks++;
        if ({ld1, busy1, done1, err1} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags got ld=%b busy=%b done=%b err=%b want all 0", ld1, busy1, done1, err1);
        end
        n_checks++;
        if (tau2 !== flat2(0) || ld2 !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_dut2 tau=%h ld=%b want %h/0", tau2, ld2, flat2(0));
        end
    endtask

    task automatic test_good_frame();
        send_frame(8, 2, 2, 8'hA5, 8'h3C, 8'h81, 0);
        n_checks++;
        if (o_busy !== 1'b1 || o_early !== 1'b0) begin
            n_fail++;
            $display("FAIL good_busy busy=%b early_pulse=%b want 1/0", o_busy, o_early);
        end
        n_checks++;
        if (o_done1 !== 1'b1 || o_err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL good_pulse done=%b err=%b want 1/0", o_done1, o_err1);
        end
        n_checks++;
        if (tau1[23:16] !== 8'hA5 || wt1[23:16] !== 8'h3C || th1[23:16] !== 8'h81) begin
            n_fail++;
            $display("FAIL good_ch2 got %h/%h/%h want a5/3c/81", tau1[23:16], wt1[23:16], th1[23:16]);
        end
        n_checks++;
        if (tau1 !== flat1(0) || wt1 !== flat1(1) || th1 !== flat1(2) || ld1 !== 4'b0100) begin
            n_fail++;
            $display("FAIL good_others tau=%h w=%h th=%h ld=%b want %h/%h/%h/0100",
                     tau1, wt1, th1, ld1, flat1(0), flat1(1), flat1(2));
        end
        @(posedge clk); #1;
        n_checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL good_pulse_width done=%b busy=%b want 0/0", done1, busy1);
        end
    endtask

    task automatic test_bad_length();
        int lens [2] = '{7, 9};
        foreach (lens[i]) begin
            send_frame(lens[i], 1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0);
            n_checks++;
            if (o_err1 !== 1'b1 || o_done1 !== 1'b0 || o_err2 !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_len_%0d err=%b done=%b err2=%b want 1/0/1", lens[i], o_err1, o_done1, o_err2);
            end
            n_checks++;
            if (tau1 !== flat1(0) || wt1 !== flat1(1) || th1 !== flat1(2) || ld1 !== m1_ld) begin
                n_fail++;
                $display("FAIL bad_len_%0d_state tau=%h ld=%b want %h/%b", lens[i], tau1, ld1, flat1(0), m1_ld);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8, 0, 0, 8'h11, 8'h22, 8'h33, 0);
        n_checks++;
        if (o_done1 !== 1'b1 || tau1 !== flat1(0)) begin
            n_fail++;
            $display("FAIL b2b_first done=%b tau=%h want 1/%h", o_done1, tau1, flat1(0));
        end
        send_frame(8, 3, 3, 8'hC7, 8'h5E, 8'hF0, 0);
        n_checks++;
        if (o_early !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap early_pulse=%b busy=%b want 0/1", o_early, o_busy);
        end
        n_checks++;
        if (o_done1 !== 1'b1 || tau1 !== flat1(0) || wt1 !== flat1(1) || th1 !== flat1(2)
            || ld1 !== 4'b1101) begin
            n_fail++;
            $display("FAIL b2b_second done=%b tau=%h th=%h ld=%b want 1/%h/%h/1101",
                     o_done1, tau1, th1, ld1, flat1(0), flat1(2));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) begin
            set_vars = 1'b1; ch_sel = 2'd1; ch_sel2 = 3'd1;
            expd = 1'b1; w = 1'b1; t = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; set_vars = 1'b0;
        model_reset();
        n_checks++;
        if (tau1 !== flat1(0) || wt1 !== flat1(1) || th1 !== flat1(2) || ld1 !== 4'b0
            || {busy1, done1, err1} !== 3'b0) begin
            n_fail++;
            $display("FAIL rst_mid tau=%h ld=%b busy=%b done=%b err=%b want %h/0/0/0/0",
                     tau1, ld1, busy1, done1, err1, flat1(0));
        end
        @(posedge clk); #1;
        n_checks++;
        if (done1 !== 1'b0 || err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_nopulse done=%b err=%b want 0/0", done1, err1);
        end
        send_frame(8, 1, 1, 8'h6B, 8'h9D, 8'h2E, 0);
        n_checks++;
        if (o_done1 !== 1'b1 || tau1 !== flat1(0) || wt1 !== flat1(1) || th1 !== flat1(2) || ld1 !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_mid_next done=%b tau=%h ld=%b want 1/%h/0010", o_done1, tau1, ld1, flat1(0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_channel_select();
        int c2s [3] = '{5, 6, 7};
        foreach (c2s[i]) begin
            send_frame(8, 1, c2s[i], 8'($urandom), 8'($urandom), 8'($urandom), 0);
            n_checks++;
            if (o_err2 !== 1'b1 || o_done2 !== 1'b0 || tau2 !== flat2(0) || ld2 !== m2_ld) begin
                n_fail++;
                $display("FAIL bad_ch_%0d err=%b done=%b tau=%h ld=%b want 1/0/%h/%b",
                         c2s[i], o_err2, o_done2, tau2, ld2, flat2(0), m2_ld);
            end
            @(posedge clk); #1;
        end
        send_frame(8, 1, 4, 8'hE1, 8'h7A, 8'h0F, 1);
        n_checks++;
        if (o_done1 !== 1'b1 || tau1 !== flat1(0) || wt1 !== flat1(1) || th1 !== flat1(2)) begin
            n_fail++;
            $display("FAIL toggle_ch done=%b tau=%h want 1/%h", o_done1, tau1, flat1(0));
        end
        n_checks++;
        if (o_done2 !== 1'b1 || tau2 !== flat2(0) || ld2 !== m2_ld) begin
            n_fail++;
            $display("FAIL toggle_ch4 done=%b tau=%h ld=%b want 1/%h/%b", o_done2, tau2, ld2, flat2(0), m2_ld);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int len, c1, c2;
            len = (n % 3 == 0) ? int'($urandom_range(6, 10)) : 8;
            c1  = int'($urandom_range(0, 3));
            c2  = int'($urandom_range(0, 7));
            send_frame(len, c1, c2, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            n_checks++;
            if (o_done1 !== e_done1 || o_err1 !== e_err1 || o_done2 !== e_done2 || o_err2 !== e_err2) begin
                n_fail++;
                $display("FAIL rand_%0d_pulse got %b%b%b%b want %b%b%b%b", n,
                         o_done1, o_err1, o_done2, o_err2, e_done1, e_err1, e_done2, e_err2);
            end
            n_checks++;
            if (tau1 !== flat1(0) || wt1 !== flat1(1) || th1 !== flat1(2) || ld1 !== m1_ld
                || tau2 !== flat2(0) || wt2 !== flat2(1) || th2 !== flat2(2) || ld2 !== m2_ld) begin
                n_fail++;
                $display("FAIL rand_%0d_regs tau=%h w=%h th=%h ld=%b want %h/%h/%h/%b", n,
                         tau1, wt1, th1, ld1, flat1(0), flat1(1), flat1(2), m1_ld);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_length();
        test_back_to_back();
        test_reset_mid_frame();
        test_channel_select();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
